// File: rtl/key_filter_pkg.sv
// Shared types and constants for the push-button debouncer.
package key_filter_pkg;

  localparam int unsigned KEY_CNT_MAX_DEF  = 999_999;
  localparam int unsigned KEY_LONG_MAX_DEF = 49_999_999;
  localparam logic        KEY_PRESSED      = 1'b0;

  typedef enum logic [1:0] {
    KEY_UP      = 2'd0,
    KEY_FILT_DN = 2'd1,
    KEY_DOWN    = 2'd2,
    KEY_FILT_UP = 2'd3
  } key_state_t;

  // Bits needed to count 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous board input.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meta     <= RST_VAL;
      sync_out <= RST_VAL;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/key_filter.sv
// Debounces an active-low push-button: clean level plus press/release strobes.
// Optional long-press pulse is built when KEY_FILTER_LONG_EN is defined.
module key_filter
  import key_filter_pkg::*;
#(
  parameter int unsigned CNT_MAX  = KEY_CNT_MAX_DEF
`ifdef KEY_FILTER_LONG_EN
  ,
  parameter int unsigned LONG_MAX = KEY_LONG_MAX_DEF
`endif
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release
`ifdef KEY_FILTER_LONG_EN
  ,
  output logic key_long
`endif
);

  localparam int unsigned    CNT_W    = cnt_width(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);

  logic             key_sync;
  key_state_t       state;
  key_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             level_nxt;
  logic             press_nxt;
  logic             release_nxt;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .async_in  (key_in),
    .sync_out  (key_sync)
  );

  // State and filter counter register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= KEY_UP;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state; the counter only runs inside the two filter states.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      KEY_UP: begin
        if (key_sync == KEY_PRESSED) state_nxt = KEY_FILT_DN;
      end
      KEY_FILT_DN: begin
        if (key_sync != KEY_PRESSED)  state_nxt = KEY_UP;
        else if (cnt == CNT_LAST)     state_nxt = KEY_DOWN;
        else                          cnt_nxt   = cnt + CNT_W'(1);
      end
      KEY_DOWN: begin
        if (key_sync != KEY_PRESSED) state_nxt = KEY_FILT_UP;
      end
      KEY_FILT_UP: begin
        if (key_sync == KEY_PRESSED)  state_nxt = KEY_DOWN;
        else if (cnt == CNT_LAST)     state_nxt = KEY_UP;
        else                          cnt_nxt   = cnt + CNT_W'(1);
      end
      default: state_nxt = KEY_UP;
    endcase
  end

  // Output next-values: strobes coincide with the level change.
  always_comb begin
    press_nxt   = (state == KEY_FILT_DN) && (key_sync == KEY_PRESSED) && (cnt == CNT_LAST);
    release_nxt = (state == KEY_FILT_UP) && (key_sync != KEY_PRESSED) && (cnt == CNT_LAST);
    level_nxt   = key_level;
    if (press_nxt)   level_nxt = KEY_PRESSED;
    if (release_nxt) level_nxt = ~KEY_PRESSED;
  end

  // Registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_level   <= ~KEY_PRESSED;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_level   <= level_nxt;
      key_press   <= press_nxt;
      key_release <= release_nxt;
    end
  end

`ifdef KEY_FILTER_LONG_EN
  localparam int unsigned      LONG_W    = cnt_width(LONG_MAX);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_MAX);

  logic [LONG_W-1:0] long_cnt;
  logic              long_done;
  logic              key_held;
  logic              long_nxt;

  // Held time spans bounces during release, so FILT_UP keeps counting.
  assign key_held = (state == KEY_DOWN) || (state == KEY_FILT_UP);
  assign long_nxt = key_held && (long_cnt == LONG_LAST) && !long_done;

  // Saturating hold counter; long_done limits the pulse to one per press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      long_cnt  <= '0;
      long_done <= 1'b0;
      key_long  <= 1'b0;
    end else begin
      key_long <= long_nxt;
      if (state_nxt == KEY_UP) begin
        long_cnt  <= '0;
        long_done <= 1'b0;
      end else if (key_held) begin
        if (long_cnt != LONG_LAST) long_cnt <= long_cnt + LONG_W'(1);
        if (long_nxt)              long_done <= 1'b1;
      end
    end
  end
`endif

endmodule
